timer_loader: RTL

TIMER_LOADER -- requirements
Module: timer_loader

---
 rtl/timer_pkg.sv | 24 ++
 rtl/bcd_digit_shifter.sv | 61 ++++++
 rtl/timer_loader.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared types and constants for the timer loader.
//   state_e       : controller states IDLE, ENTRY, LOAD, RUN
//   bcd_t         : one 4-bit BCD keypad digit
//   MAX_SEC_TENS  : largest legal tens-of-seconds digit
//   is_bcd_digit  : true for digit codes 0..9
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_LOAD  = 2'd2,
    ST_RUN   = 2'd3
  } state_e;

  typedef logic [3:0] bcd_t;

  localparam bcd_t MAX_SEC_TENS = 4'd5;
  localparam logic [2:0] MAX_DIGITS = 3'd4;

  function automatic logic is_bcd_digit(input bcd_t d);
    return (d <= 4'd9);
  endfunction

endpackage

// File: rtl/bcd_digit_shifter.sv
// Four-digit BCD entry register with digit counter.
// A new digit enters at the least significant position (sec_ones) and the
// older digits move up one place. Also applies the seconds-tens clamp when
// asked to, and clears on request.
// Ports:
//   clk, clrn     : clock, synchronous active-low reset
//   clear         : zero data and count (wins over everything else)
//   clamp_en      : saturate sec_tens to MAX_SEC_TENS this cycle
//   shift_en      : accept digit if fewer than four are held
//   digit         : BCD digit to insert
//   data          : {min_tens, min_ones, sec_tens, sec_ones}
//   count         : digits held, 0..4
//   full          : four digits held
module bcd_digit_shifter
  import timer_pkg::*;
(
  input  logic        clk,
  input  logic        clrn,
  input  logic        clear,
  input  logic        clamp_en,
  input  logic        shift_en,
  input  bcd_t        digit,
  output logic [15:0] data,
  output logic [2:0]  count,
  output logic        full
);

  logic [15:0] data_q, data_d;
  logic [2:0]  count_q, count_d;

  always_comb begin
    data_d  = data_q;
    count_d = count_q;
    if (clear) begin
      data_d  = '0;
      count_d = '0;
    end else if (clamp_en) begin
      if (data_q[7:4] > MAX_SEC_TENS) begin
        data_d[7:4] = MAX_SEC_TENS;
      end
    end else if (shift_en && (count_q < MAX_DIGITS)) begin
      data_d  = {data_q[11:0], digit};
      count_d = count_q + 3'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      data_q  <= '0;
      count_q <= '0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
    end
  end

  assign data  = data_q;
  assign count = count_q;
  assign full  = (count_q == MAX_DIGITS);

endmodule

// File: rtl/timer_loader.sv
// Keypad-driven loader for a cascaded BCD down-counter chain.
// Collects up to four BCD digits, parallel-loads them into the counters with
// an active-low strobe held LOAD_CYCLES cycles, then enables counting until
// the chain reports zero.
// Optional build macro TIMER_LOADER_SEC_CLAMP_EN: saturate sec_tens to 5 as
// the load begins; otherwise the entered digits are loaded unchanged.
// Ports:
//   clk, clrn          : clock, synchronous active-low reset
//   key_valid/key_digit: keypad strobe and BCD digit
//   start, cancel      : load-and-run request, abort
//   timer_zero         : zero flag from the counter chain
//   data               : load value to the counters
//   loadn, en          : parallel-load strobe (low active), count enable
//   busy, done         : LOAD/RUN indicator, end-of-run pulse
//   key_err            : pulse for a rejected digit
//   digit_count        : digits entered
//
// state | meaning
// IDLE  | nothing entered, waiting for a digit
// ENTRY | at least one digit accepted, waiting for more or start
// LOAD  | loadn held low, data frozen
// RUN   | counters enabled, waiting for timer_zero
module timer_loader
  import timer_pkg::*;
#(
  parameter int LOAD_CYCLES = 1
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        start,
  input  logic        cancel,
  input  logic        timer_zero,
  output logic [15:0] data,
  output logic        loadn,
  output logic        en,
  output logic        busy,
  output logic        done,
  output logic        key_err,
  output logic [2:0]  digit_count
);

  // Load timer counts down from LOAD_CYCLES-1; terminal count ends LOAD.
  localparam logic [2:0] LOAD_INIT = 3'(LOAD_CYCLES - 1);

`ifdef TIMER_LOADER_SEC_CLAMP_EN
  localparam logic CLAMP_ON = 1'b1;
`else
  localparam logic CLAMP_ON = 1'b0;
`endif

  state_e     state_q, state_d;
  logic [2:0] load_cnt_q, load_cnt_d;
  logic       loadn_q, loadn_d;
  logic       en_q, en_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       key_err_q, key_err_d;

  logic        shift_en;
  logic        clear;
  logic        load_go;
  logic        clamp_en;
  logic [15:0] sh_data;
  logic [2:0]  sh_count;
  logic        sh_full;

  bcd_digit_shifter u_shifter (
    .clk      (clk),
    .clrn     (clrn),
    .clear    (clear),
    .clamp_en (clamp_en),
    .shift_en (shift_en),
    .digit    (key_digit),
    .data     (sh_data),
    .count    (sh_count),
    .full     (sh_full)
  );

  assign clamp_en = load_go & CLAMP_ON;

  always_comb begin
    state_d    = state_q;
    load_cnt_d = load_cnt_q;
    loadn_d    = loadn_q;
    en_d       = en_q;
    done_d     = 1'b0;
    key_err_d  = 1'b0;
    shift_en   = 1'b0;
    clear      = 1'b0;
    load_go    = 1'b0;

    if (cancel) begin
      state_d = ST_IDLE;
      loadn_d = 1'b1;
      en_d    = 1'b0;
      clear   = 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_ENTRY: begin
          // An ignored start (IDLE, or nothing but zeros entered) does not
          // block a key in the same cycle; an accepted start swallows it.
          if (start && (state_q == ST_ENTRY) && (sh_data != 16'h0000)) begin
            state_d    = ST_LOAD;
            loadn_d    = 1'b0;
            load_cnt_d = LOAD_INIT;
            load_go    = 1'b1;
          end else if (key_valid) begin
            if (is_bcd_digit(key_digit) && !sh_full) begin
              shift_en = 1'b1;
              state_d  = ST_ENTRY;
            end else begin
              key_err_d = 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (load_cnt_q == 3'd0) begin
            state_d = ST_RUN;
            loadn_d = 1'b1;
            en_d    = 1'b1;
          end else begin
            load_cnt_d = load_cnt_q - 3'd1;
          end
        end
        ST_RUN: begin
          if (timer_zero) begin
            state_d = ST_IDLE;
            en_d    = 1'b0;
            done_d  = 1'b1;
            clear   = 1'b1;
          end
        end
        default: begin
          state_d = ST_IDLE;
          loadn_d = 1'b1;
          en_d    = 1'b0;
          clear   = 1'b1;
        end
      endcase
    end

    busy_d = (state_d == ST_LOAD) || (state_d == ST_RUN);
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q    <= ST_IDLE;
      load_cnt_q <= '0;
      loadn_q    <= 1'b1;
      en_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      key_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      load_cnt_q <= load_cnt_d;
      loadn_q    <= loadn_d;
      en_q       <= en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      key_err_q  <= key_err_d;
    end
  end

  assign data        = sh_data;
  assign digit_count = sh_count;
  assign loadn       = loadn_q;
  assign en          = en_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign key_err     = key_err_q;

endmodule
